// File: rtl/psum_writeback_if.sv
// ---------------------------------------------------------------------------
// psum_writeback_if
// Bundles the frame configuration, the partial-sum input stream and the
// output feature-map SRAM write port of psum_writeback.
//
//   start      1        one-cycle frame start pulse
//   base_addr  ADDR_W   first SRAM word address of the frame
//   pix_count  CNT_W    number of results in the frame
//   bias       DATA_W   signed per-channel bias
//   shift      5        requantization right shift (values above 24 act as 24)
//   relu_en    1        clamp negative biased sums to zero
//   in_valid   1        in_data valid this cycle
//   in_data    DATA_W   signed accumulated sum
//   mem_wr_en  1        SRAM write strobe, one cycle per word
//   mem_addr   ADDR_W   SRAM word address
//   mem_wdata  32       packed bytes, lane k at [8k+7:8k]
//   mem_be     4        byte enables, bit k enables lane k
//   busy       1        frame in progress
//   done       1        end-of-frame pulse
//   ovf        1        sticky saturation flag
//
// slave  : the write-back block.
// master : whoever issues frames, feeds sums and observes the SRAM port.
// ---------------------------------------------------------------------------
interface psum_writeback_if #(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  pix_count;
  logic [DATA_W-1:0] bias;
  logic [4:0]        shift;
  logic              relu_en;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              busy;
  logic              done;
  logic              ovf;

  modport slave (
    input  start, base_addr, pix_count, bias, shift, relu_en, in_valid, in_data,
    output mem_wr_en, mem_addr, mem_wdata, mem_be, busy, done, ovf
  );

  modport master (
    output start, base_addr, pix_count, bias, shift, relu_en, in_valid, in_data,
    input  mem_wr_en, mem_addr, mem_wdata, mem_be, busy, done, ovf
  );

endinterface

// File: rtl/psum_writeback.sv
// ---------------------------------------------------------------------------
// psum_writeback
// Takes finished accumulated convolution sums, adds a bias, applies optional
// ReLU, requantizes to int8 with a rounding arithmetic right shift and
// saturation, packs four bytes per word and writes the words to the output
// feature-map SRAM at consecutive word addresses, one frame per start pulse.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    psum_writeback_if.slave (config, sum stream, SRAM write port,
//          busy/done/ovf status)
//
// Pipeline: input register -> S1 bias add -> S2 relu/round/shift ->
// S3 saturate -> pack/write. A sample accepted at edge t is in S3 at t+3 and
// the word it completes is presented on the SRAM port at t+4.
// ---------------------------------------------------------------------------
module psum_writeback #(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  psum_writeback_if.slave   bus
);

  localparam int unsigned S1_W = DATA_W + 1;  // biased sum
  localparam int unsigned R_W  = DATA_W + 2;  // rounding headroom
  localparam int unsigned SH_W = 5;

  localparam logic [SH_W-1:0]       SH_MAX = SH_W'(24);
  localparam logic signed [R_W-1:0] Q_MAX  = R_W'(127);
  localparam logic signed [R_W-1:0] Q_MIN  = -R_W'(128);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Frame configuration latched at start
  logic [CNT_W-1:0]         r_pix_count;
  logic [CNT_W-1:0]         r_acc_cnt;
  logic signed [DATA_W-1:0] r_bias;
  logic [SH_W-1:0]          r_shift;
  logic                     r_relu;

  // Pipeline
  logic                     r_v0, r_v1, r_v2, r_v3;
  logic                     r_l0, r_l1, r_l2, r_l3;
  logic signed [DATA_W-1:0] r_d0;
  logic signed [S1_W-1:0]   r_s1;
  logic signed [R_W-1:0]    r_s2;
  logic [7:0]               r_s3;

  // Packer
  logic [1:0]               r_idx;
  logic [31:0]              r_lanes;
  logic [ADDR_W-1:0]        r_addr;

  // Registered outputs
  logic                     r_mem_wr_en;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic [31:0]              r_mem_wdata;
  logic [3:0]               r_mem_be;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ovf;

  logic                     w_accept;
  logic                     w_cfg_load;
  logic                     w_start_idle;
  logic                     w_last;
  logic                     w_pipe_busy;
  logic                     w_busy_nxt;
  logic                     w_done_nxt;

  logic signed [S1_W-1:0]   w_t;
  logic signed [R_W-1:0]    w_t_ext;
  logic signed [R_W-1:0]    w_rnd;
  logic signed [R_W-1:0]    w_r;
  logic                     w_sat_hi;
  logic                     w_sat_lo;
  logic [7:0]               w_q;
  logic [31:0]              w_word;
  logic [3:0]               w_be;
  logic                     w_issue;

  // The sample being accepted now is the final one of the frame
  assign w_last      = (r_acc_cnt + CNT_W'(1)) == r_pix_count;
  assign w_pipe_busy = r_v0 | r_v1 | r_v2 | r_v3;

  // FSM state register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // FSM next state and control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_cfg_load   = 1'b0;
    w_start_idle = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_idle = 1'b1;
          if (bus.pix_count != '0) begin
            w_cfg_load  = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (bus.in_valid && (r_acc_cnt != r_pix_count)) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // The final write leaves on the same edge that empties S3
        if (!w_pipe_busy) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_FLUSH);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Frame configuration and accepted-sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_count <= '0;
      r_acc_cnt   <= '0;
      r_bias      <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
    end else if (w_cfg_load) begin
      r_pix_count <= bus.pix_count;
      r_acc_cnt   <= '0;
      r_bias      <= $signed(bus.bias);
      r_shift     <= (bus.shift > SH_MAX) ? SH_MAX : bus.shift;
      r_relu      <= bus.relu_en;
    end else if (w_accept) begin
      r_acc_cnt   <= r_acc_cnt + CNT_W'(1);
    end
  end

  // S2: ReLU, then round-half-up arithmetic shift
  assign w_t     = (r_relu && r_s1[S1_W-1]) ? '0 : r_s1;
  assign w_t_ext = R_W'(w_t);
  assign w_rnd   = (r_shift == '0) ? '0 : (R_W'(1) <<< (r_shift - SH_W'(1)));
  assign w_r     = (w_t_ext + w_rnd) >>> r_shift;

  // S3: saturate to int8
  assign w_sat_hi = r_s2 > Q_MAX;
  assign w_sat_lo = r_s2 < Q_MIN;
  assign w_q      = w_sat_hi ? 8'h7F : (w_sat_lo ? 8'h80 : r_s2[7:0]);

  // Data pipeline; valids and last-flags travel alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_l0 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
      r_l3 <= 1'b0;
      r_d0 <= '0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_v0 <= w_accept;
      r_l0 <= w_accept & w_last;
      if (w_accept) begin
        r_d0 <= $signed(bus.in_data);
      end
      r_v1 <= r_v0;
      r_l1 <= r_l0;
      if (r_v0) begin
        r_s1 <= S1_W'(r_d0) + S1_W'(r_bias);
      end
      r_v2 <= r_v1;
      r_l2 <= r_l1;
      if (r_v1) begin
        r_s2 <= w_r;
      end
      r_v3 <= r_v2;
      r_l3 <= r_l2;
      if (r_v2) begin
        r_s3 <= w_q;
      end
    end
  end

  // Current word with the S3 byte merged into its lane, and its enables
  always_comb begin
    w_word = r_lanes;
    w_be   = 4'b0000;
    case (r_idx)
      2'd0: begin
        w_word[7:0] = r_s3;
        w_be        = 4'b0001;
      end
      2'd1: begin
        w_word[15:8] = r_s3;
        w_be         = 4'b0011;
      end
      2'd2: begin
        w_word[23:16] = r_s3;
        w_be          = 4'b0111;
      end
      default: begin
        w_word[31:24] = r_s3;
        w_be          = 4'b1111;
      end
    endcase
  end

  // A word goes out when lane 3 fills or the frame's last byte lands
  assign w_issue = r_v3 && ((r_idx == 2'd3) || r_l3);

  // Packer, address generator, SRAM port and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_lanes     <= '0;
      r_addr      <= '0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_mem_wr_en <= w_issue;
      if (w_cfg_load) begin
        r_addr  <= bus.base_addr;
        r_idx   <= '0;
        r_lanes <= '0;
      end else if (r_v3) begin
        if (w_issue) begin
          // Lanes not yet written are still zero from the previous clear
          r_mem_addr  <= r_addr;
          r_mem_wdata <= w_word;
          r_mem_be    <= w_be;
          r_addr      <= r_addr + ADDR_W'(1);
          r_idx       <= '0;
          r_lanes     <= '0;
        end else begin
          r_lanes <= w_word;
          r_idx   <= r_idx + 2'd1;
        end
      end
      if (w_start_idle) begin
        r_ovf <= 1'b0;
      end else if (r_v2 && (w_sat_hi || w_sat_lo)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.mem_wr_en = r_mem_wr_en;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_psum_writeback.sv
// ---------------------------------------------------------------------------
// tb_psum_writeback
// Directed and randomized frames for psum_writeback. Expected SRAM words are
// built from a plain-arithmetic model of bias/ReLU/rounding/saturation and
// byte packing, then compared with the writes seen on the SRAM port.
// ---------------------------------------------------------------------------
module tb_psum_writeback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  psum_writeback_if bus ();

  psum_writeback u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed SRAM writes and done pulses
  logic [15:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];
  int          wq_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
      wq_be.push_back(bus.mem_be);
      wq_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Stimulus and expectations
  longint      stim_q[$];
  int          gap_q[$];
  int          feed_edge[$];
  logic [15:0] ex_addr[$];
  logic [31:0] ex_data[$];
  logic [3:0]  ex_be[$];
  bit          ex_ovf;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // int8 result of one sum: bias, ReLU, round half up, divide, clamp
  function automatic logic [7:0] ref_q(input longint d, input longint b, input int sh,
                                       input bit relu, output bit sat);
    longint s, r;
    int     e;
    s = d + b;
    if (relu && s < 0) s = 0;
    e = (sh > 24) ? 24 : sh;
    if (e == 0) r = s;
    else        r = floor_div(s + (longint'(1) << (e - 1)), longint'(1) << e);
    sat = 1'b0;
    if (r > 127) begin
      r = 127; sat = 1'b1;
    end else if (r < -128) begin
      r = -128; sat = 1'b1;
    end
    return 8'(r);
  endfunction

  task automatic build_expect(input logic [15:0] base, input int cnt, input longint b,
                              input int sh, input bit relu);
    logic [31:0] w;
    logic [15:0] a;
    logic [7:0]  q;
    int          lane;
    bit          s;
    ex_addr.delete(); ex_data.delete(); ex_be.delete();
    ex_ovf = 1'b0;
    w = '0; lane = 0; a = base;
    for (int i = 0; i < cnt; i++) begin
      q = ref_q(stim_q[i], b, sh, relu, s);
      ex_ovf = ex_ovf | s;
      w = w | (32'(q) << (8 * lane));
      lane++;
      if (lane == 4 || i == cnt - 1) begin
        ex_addr.push_back(a);
        ex_data.push_back(w);
        ex_be.push_back(4'((1 << lane) - 1));
        a = a + 16'd1;
        w = '0;
        lane = 0;
      end
    end
  endtask

  task automatic clear_obs();
    wq_addr.delete(); wq_data.delete(); wq_be.delete(); wq_cyc.delete();
  endtask

  task automatic do_start(input logic [15:0] base, input int cnt, input longint b,
                          input int sh, input bit relu);
    bus.base_addr = base;
    bus.pix_count = 16'(cnt);
    bus.bias      = 25'(b);
    bus.shift     = 5'(sh);
    bus.relu_en   = relu;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic feed_all();
    feed_edge.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 25'(stim_q[i]);
      @(posedge clk); #1;
      feed_edge.push_back(cyc);
      bus.in_valid = 1'b0;
      if (i < gap_q.size()) begin
        repeat (gap_q[i]) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_done(input string tag, input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt > d0), 1'b1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, "_nwr"}, wq_addr.size(), ex_addr.size());
    for (int i = 0; i < ex_addr.size() && i < wq_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wq_addr[i], ex_addr[i]);
      check($sformatf("%s_data%0d", tag, i), wq_data[i], ex_data[i]);
      check($sformatf("%s_be%0d", tag, i), wq_be[i], ex_be[i]);
    end
    check({tag, "_ovf"}, bus.ovf, ex_ovf);
    check({tag, "_busy_end"}, bus.busy, 1'b0);
  endtask

  task automatic run_frame(input logic [15:0] base, input int cnt, input longint b,
                           input int sh, input bit relu, input string tag);
    int d0;
    clear_obs();
    build_expect(base, cnt, b, sh, relu);
    d0 = done_cnt;
    do_start(base, cnt, b, sh, relu);
    feed_all();
    wait_done(tag, d0);
    cmp_writes(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, bus.mem_wr_en, 1'b0);
    check({tag, "_addr"},  bus.mem_addr,  16'h0);
    check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
    check({tag, "_be"},    bus.mem_be,    4'h0);
    check({tag, "_busy"},  bus.busy,      1'b0);
    check({tag, "_done"},  bus.done,      1'b0);
    check({tag, "_ovf"},   bus.ovf,       1'b0);
  endtask

  // Directed single-sample requantization cases
  longint t3_d[5]   = '{5, -3, 6, -5, 10};
  longint t3_b[5]   = '{0, 0, 0, 0, -10};
  int     t3_sh[5]  = '{1, 1, 2, 1, 1};
  bit     t3_r[5]   = '{0, 0, 0, 1, 0};
  logic [7:0] t3_e[5] = '{8'h03, 8'hFF, 8'h02, 8'h00, 8'h00};

  initial begin
    int          d0;
    int          k;
    int          cnt;
    int          sh;
    bit          relu;
    logic [15:0] base;
    logic signed [24:0] rv;
    longint      b;

    bus.start = 1'b0; bus.base_addr = '0; bus.pix_count = '0; bus.bias = '0;
    bus.shift = '0; bus.relu_en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four consecutive samples, one full word
    stim_q = '{1, 2, 3, 4};
    gap_q  = '{0, 0, 0, 0};
    run_frame(16'h0010, 4, 0, 0, 1'b0, "t1");
    if (wq_data.size() > 0) begin
      check("t1_wdata_const", wq_data[0], 32'h04030201);
      check("t1_write_lat", wq_cyc[0] - feed_edge[3], 4);
      check("t1_done_lat", done_cyc - wq_cyc[0], 1);
    end

    // Gapped input, partial trailing word, extra in_valid ignored
    stim_q = '{1, 2, 3, 4, 5, 6, 7};
    gap_q  = '{0, 3, 0, 0, 0, 0, 0};
    run_frame(16'h0010, 6, 0, 0, 1'b0, "t2");
    if (wq_data.size() > 1) begin
      check("t2_w1_const", wq_data[1], 32'h00000605);
      check("t2_be1_const", wq_be[1], 4'h3);
    end

    // Rounding, ReLU and bias cases
    for (int i = 0; i < 5; i++) begin
      stim_q = '{t3_d[i]};
      gap_q  = '{0};
      run_frame(16'h0100, 1, t3_b[i], t3_sh[i], t3_r[i], $sformatf("t3_%0d", i));
      if (wq_data.size() > 0)
        check($sformatf("t3_%0d_byte_const", i), wq_data[0][7:0], t3_e[i]);
    end

    // Saturation sets ovf; the next start clears it
    stim_q = '{1000, -1000};
    gap_q  = '{0, 0};
    run_frame(16'h0200, 2, 0, 0, 1'b0, "t4");
    check("t4_ovf_const", bus.ovf, 1'b1);
    if (wq_data.size() > 0) check("t4_word_const", wq_data[0], 32'h0000807F);
    stim_q = '{7};
    gap_q  = '{0};
    run_frame(16'h0201, 1, 0, 0, 1'b0, "t4b");
    check("t4b_ovf_cleared", bus.ovf, 1'b0);

    // Empty frame
    clear_obs();
    do_start(16'h0020, 0, 0, 0, 1'b0);
    k = 0;
    while (bus.done !== 1'b1 && k < 2) begin @(posedge clk); #1; k++; end
    check("t5_done_fast", bus.done, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check("t5_no_write", wq_addr.size(), 0);

    // start while busy must not relatch base_addr
    stim_q = '{9, 8, 7, 6};
    gap_q  = '{0, 0, 0, 0};
    clear_obs();
    build_expect(16'h0040, 4, 0, 0, 1'b0);
    d0 = done_cnt;
    do_start(16'h0040, 4, 0, 0, 1'b0);
    bus.base_addr = 16'h0099;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed_all();
    wait_done("t5b", d0);
    cmp_writes("t5b");

    // Asynchronous reset mid-frame
    clear_obs();
    do_start(16'h0030, 4, 0, 0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 25'd1;
    @(posedge clk); #1;
    bus.in_data = 25'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("t6_busy_pre", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    repeat (6) begin @(posedge clk); #1; end
    check("t6_no_write", wq_addr.size(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim_q = '{1, 2, 3, 4};
    gap_q  = '{0, 0, 0, 0};
    run_frame(16'h0030, 4, 0, 0, 1'b0, "t6b");

    // Randomized frames, some straddling the address wrap
    for (int f = 0; f < 10; f++) begin
      base = (f % 3 == 0) ? 16'hFFFE : 16'($urandom);
      cnt  = $urandom_range(1, 13);
      sh   = $urandom_range(0, 31);
      relu = 1'($urandom);
      rv   = 25'($urandom);
      b    = (f % 2 == 0) ? longint'($urandom_range(0, 400)) - 200 : longint'(rv);
      stim_q.delete();
      gap_q.delete();
      for (int i = 0; i < cnt; i++) begin
        rv = 25'($urandom);
        if (f % 2 == 0) stim_q.push_back(longint'($urandom_range(0, 600)) - 300);
        else            stim_q.push_back(longint'(rv));
        gap_q.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
      run_frame(base, cnt, b, sh, relu, $sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Consumes the finished 25-bit accumulated convolution sums that the partial-sum buffer drains when its valid output is high.
- Adds a per-channel bias and applies optional ReLU.
- Requantizes each sum to 8-bit signed with a rounding arithmetic shift and saturation.
- Packs four results per 32-bit word and writes the words to the output feature-map SRAM at sequential word addresses, under a frame-level start/done handshake.

Parameters:
- DATA_W, 25, width of the incoming partial sum and of the bias.
- ADDR_W, 16, output SRAM word-address width.
- CNT_W, 16, width of the per-frame pixel counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; latches config and begins a frame.
- base_addr  in  ADDR_W  first SRAM word address of the frame.
- pix_count  in  CNT_W  number of results in the frame.
- bias  in  DATA_W  signed bias added to every sum.
- shift  in  5  requantization right-shift amount, 0..24.
- relu_en  in  1  when 1, negative biased sums are clamped to 0.
- in_valid  in  1  in_data is valid this cycle (driven by the buffer's valid output).
- in_data  in  DATA_W  signed accumulated sum.
- mem_wr_en  out  1  SRAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_wdata  out  32  packed bytes; lane k is at bits [8k+7:8k].
- mem_be  out  4  byte enables, bit k enables lane k.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle pulse at the end of a frame.
- ovf  out  1  sticky saturation flag; cleared on start.

Behaviour:
- Reset: FSM goes to IDLE. Every output is 0. Pipeline valids, lane index, pixel counter and address register are cleared. Reset is asynchronous and may occur mid-frame; the in-flight word is discarded and never written.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE, start=1, pix_count>0: latch base_addr, pix_count, bias, shift and relu_en; clear ovf, lane index and accepted count; go to RUN.
  - IDLE, start=1, pix_count=0: go straight to DONE with no write.
  - start is ignored in RUN, FLUSH and DONE.
  - RUN: each cycle with in_valid=1 accepts one sample and increments the accepted count. When accepted count reaches pix_count, go to FLUSH.
  - in_valid is ignored in IDLE, FLUSH and DONE, and after the count is reached.
  - FLUSH: wait until all pipeline valids are 0 and the final write has been issued, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Input gaps: in_valid may be gapped arbitrarily. There is no backpressure; every accepted sample must be written.
- Pipeline stage S1: s1 = sext(in_data) + sext(bias), 26 bits, no overflow possible.
- Pipeline stage S2:
  - If relu_en and s1<0, t=0; else t=s1.
  - If shift=0, r=t. Otherwise r = (t + 2^(shift-1)) >>> shift, computed at 27 bits. The rounding is round-half-up toward +inf.
  - shift values >24 are treated as 24.
- Pipeline stage S3: saturate r to [-128,127]. Any clamp sets ovf, which stays set until the next accepted start.
- Packing: the S3 result is written into lane[lane index], and the lane index increments.
- Word write: a word is issued when lane 3 is filled, or when the frame's last pixel is packed, whichever comes first.
  - The write occurs on the next cycle: mem_wr_en=1, mem_addr=current address, mem_be has a 1 for each filled lane, unfilled lanes are 0x00.
  - After the write, the address increments by 1 and the lane index resets to 0.
- Latency: a sample accepted at edge t reaches S3 at t+3, and its word write (if it completes the word) is presented at t+4.
- mem_addr, mem_wdata and mem_be hold their last values when mem_wr_en=0. Back-to-back word writes every 4 cycles are sustained at full input rate.
- Address wrap: the address wraps modulo 2^ADDR_W silently.

Test Plan:
1. base_addr=0x10, pix_count=4, bias=0, shift=0, relu_en=0; in_data=1,2,3,4 on consecutive cycles -> one write: addr=0x10, wdata=0x04030201, be=0xF, 4 cycles after the last sample; done pulses 1 cycle later; busy then drops.
2. pix_count=6, data 1..6 with a 3-cycle gap after sample 2 -> writes are (0x10, 0x04030201, 0xF) then (0x11, 0x00000605, 0x3); exactly 2 writes; a seventh in_valid is ignored.
3. shift=1, relu_en=0, bias=0:
   - in_data 5 -> 0x03
   - in_data -3 -> 0xFF
   - in_data 6 with shift=2 -> 0x02
   - in_data -5 with relu_en=1 -> 0x00
   - bias=-10, in_data 10 -> 0x00
4. shift=0: in_data 1000 -> 0x7F and ovf=1; in_data -1000 -> 0x80. The next start clears ovf to 0.
5. start with pix_count=0 -> done pulses within 2 cycles with mem_wr_en never asserted; start while busy does not change the latched base_addr.
6. Assert rst_n low after 2 of 4 samples -> all outputs go to 0 immediately and no write occurs; after release, a new start with 4 samples produces the normal single write.
